// File: rtl/spi_write_ctrl_if.sv
// spi_write_ctrl_if: pad-side SPI inputs and register-block write port
//   sck/csb/mosi      : SPI master -> slave, asynchronous to the system clock
//   wen/waddr/wdata   : one-cycle write strobe with address and data
//   busy/frame_err    : frame in progress / frame ended mid-byte
interface spi_write_ctrl_if;
  logic       sck;
  logic       csb;
  logic       mosi;
  logic       wen;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       busy;
  logic       frame_err;
  modport slave (input sck, csb, mosi, output wen, waddr, wdata, busy, frame_err);
  modport master (output sck, csb, mosi, input wen, waddr, wdata, busy, frame_err);
endinterface

// File: rtl/spi_write_ctrl.sv
// spi_write_ctrl: SPI mode-0 write-only slave producing single-cycle register writes
//   i_clk  : system clock
//   i_rstx : asynchronous active-low reset
//   bus    : slave side of spi_write_ctrl_if (SPI pads in, write port and status out)
module spi_write_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rstx,
  spi_write_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sck_s, r_csb_s, r_mosi_s;
  logic       r_sck_d, r_csb_d;
  logic [2:0] r_bitcnt;
  logic [6:0] r_shift;
  logic [7:0] r_addr, r_waddr, r_wdata;
  logic       r_wen, r_ferr;
  logic       w_sck, w_csb, w_mosi, w_sck_rise, w_csb_rise, w_csb_fall;
  logic       w_sample, w_byte_done, w_write, w_err;
  logic [7:0] w_byte;
  assign w_sck      = r_sck_s[SYNC_STAGES-1];
  assign w_csb      = r_csb_s[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_s[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_csb_rise = w_csb & ~r_csb_d;
  assign w_csb_fall = ~w_csb & r_csb_d;
  assign w_byte     = {r_shift, w_mosi};
  always_ff @(posedge i_clk or negedge i_rstx)
    if (!i_rstx) r_state <= IDLE;
    else         r_state <= w_next;
  always_comb
    w_next = w_csb_rise                         ? IDLE :
             (r_state == IDLE && w_csb_fall)    ? ADDR :
             (r_state == ADDR && w_byte_done)   ? DATA : r_state;
  // a CSB rise in the same cycle as an SCK rise suppresses the sample
  always_comb begin
    w_sample    = (r_state != IDLE) && w_sck_rise && !w_csb_rise;
    w_byte_done = w_sample && r_bitcnt == 3'd7;
    w_write     = w_byte_done && r_state == DATA;
    w_err       = w_csb_rise && r_state != IDLE && r_bitcnt != 3'd0;
  end
  always_ff @(posedge i_clk or negedge i_rstx)
    if (!i_rstx) begin
      r_sck_s  <= '0;
      r_csb_s  <= '1;
      r_mosi_s <= '0;
      r_sck_d  <= 1'b0;
      r_csb_d  <= 1'b1;
      r_bitcnt <= 3'd0;
      r_shift  <= 7'd0;
      r_addr   <= 8'd0;
      r_waddr  <= 8'd0;
      r_wdata  <= 8'd0;
      r_wen    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], bus.sck};
      r_csb_s  <= {r_csb_s[SYNC_STAGES-2:0], bus.csb};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], bus.mosi};
      r_sck_d  <= w_sck;
      r_csb_d  <= w_csb;
      r_bitcnt <= (w_csb_rise || w_csb_fall) ? 3'd0 : w_sample ? r_bitcnt + 3'd1 : r_bitcnt;
      r_shift  <= w_sample ? w_byte[6:0] : r_shift;
      r_addr   <= (r_state == ADDR && w_byte_done) ? w_byte : w_write ? r_addr + 8'd1 : r_addr;
      r_wen    <= w_write;
      r_waddr  <= w_write ? r_addr : r_waddr;
      r_wdata  <= w_write ? w_byte : r_wdata;
      r_ferr   <= w_err;
    end
  assign bus.wen       = r_wen;
  assign bus.waddr     = r_waddr;
  assign bus.wdata     = r_wdata;
  assign bus.busy      = r_state != IDLE;
  assign bus.frame_err = r_ferr;
endmodule

// File: tb/tb_spi_write_ctrl.sv
// tb_spi_write_ctrl: directed bench for spi_write_ctrl
module tb_spi_write_ctrl;
  logic clk = 1'b0;
  logic rstx = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [15:0] wq[$];
  int ferr_cnt = 0;
  int wen_long = 0;
  logic prev_wen = 1'b0;
  spi_write_ctrl_if bus();
  spi_write_ctrl #(.SYNC_STAGES(2)) dut (.i_clk(clk), .i_rstx(rstx), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.wen) wq.push_back({bus.waddr, bus.wdata});
    if (bus.wen && prev_wen) wen_long++;
    if (bus.frame_err) ferr_cnt++;
    prev_wen = bus.wen;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic b, input int h);
    bus.mosi = b;
    repeat (h) @(negedge clk);
    bus.sck = 1'b1;
    repeat (h) @(negedge clk);
    bus.sck = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int h);
    for (int i = 7; i >= 0; i--) send_bit(b[i], h);
  endtask
  task automatic frame_start(input int h);
    bus.csb = 1'b0;
    repeat (h) @(negedge clk);
  endtask
  task automatic frame_end(input int h);
    repeat (h) @(negedge clk);
    bus.csb = 1'b1;
    repeat (h + 4) @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] d;
    bus.sck = 1'b0; bus.csb = 1'b1; bus.mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_wen", bus.wen, 0);
    chk("rst_waddr", bus.waddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ferr", bus.frame_err, 0);
    rstx = 1'b1;
    repeat (4) @(negedge clk);
    // 1: single write with exact latency check on the last data bit
    wq.delete();
    d = 8'hA5;
    frame_start(8);
    chk("t1_busy", bus.busy, 1);
    send_byte(8'h01, 8);
    for (int i = 7; i >= 1; i--) send_bit(d[i], 8);
    bus.mosi = d[0];
    repeat (8) @(negedge clk);
    bus.sck = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_wen_early", bus.wen, 0);
    @(negedge clk);
    chk("t1_wen", bus.wen, 1);
    chk("t1_waddr", bus.waddr, 8'h01);
    chk("t1_wdata", bus.wdata, 8'hA5);
    @(negedge clk);
    chk("t1_wen_width", bus.wen, 0);
    repeat (4) @(negedge clk);
    bus.sck = 1'b0;
    repeat (8) @(negedge clk);
    chk("t1_busy_pre", bus.busy, 1);
    frame_end(8);
    chk("t1_busy_post", bus.busy, 0);
    chk("t1_nwr", wq.size(), 1);
    chk("t1_hold", {bus.waddr, bus.wdata}, 16'h01A5);
    // 2: burst with address wrap
    wq.delete();
    frame_start(8);
    send_byte(8'hFE, 8);
    send_byte(8'h11, 8);
    send_byte(8'h22, 8);
    send_byte(8'h33, 8);
    frame_end(8);
    chk("t2_nwr", wq.size(), 3);
    if (wq.size() == 3) begin
      chk("t2_w0", wq[0], 16'hFE11);
      chk("t2_w1", wq[1], 16'hFF22);
      chk("t2_w2", wq[2], 16'h0033);
    end
    chk("t2_ferr", ferr_cnt, 0);
    // 3: partial byte at CSB rise
    wq.delete();
    frame_start(8);
    send_byte(8'h00, 8);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 8);
    frame_end(8);
    chk("t3_nwr", wq.size(), 0);
    chk("t3_ferr", ferr_cnt, 1);
    chk("t3_idle", bus.busy, 0);
    // 4: SCK activity with CSB high
    wq.delete();
    ferr_cnt = 0;
    send_byte(8'hFF, 2);
    send_byte(8'hFF, 2);
    repeat (8) @(negedge clk);
    chk("t4_nwr", wq.size(), 0);
    chk("t4_busy", bus.busy, 0);
    chk("t4_ferr", ferr_cnt, 0);
    // 6: minimum SCK timing, same writes as slow runs
    wq.delete();
    frame_start(4);
    send_byte(8'hFE, 4);
    send_byte(8'h11, 4);
    send_byte(8'h22, 4);
    send_byte(8'h33, 4);
    frame_end(4);
    frame_start(4);
    send_byte(8'h01, 4);
    send_byte(8'hA5, 4);
    frame_end(4);
    chk("t6_nwr", wq.size(), 4);
    if (wq.size() == 4) begin
      chk("t6_w0", wq[0], 16'hFE11);
      chk("t6_w1", wq[1], 16'hFF22);
      chk("t6_w2", wq[2], 16'h0033);
      chk("t6_w3", wq[3], 16'h01A5);
    end
    chk("t6_ferr", ferr_cnt, 0);
    // 5: asynchronous reset mid-frame, then a fresh frame
    wq.delete();
    frame_start(8);
    send_byte(8'h3C, 8);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 8);
    chk("t5_busy_pre", bus.busy, 1);
    #2 rstx = 1'b0;
    #1;
    chk("t5_wen", bus.wen, 0);
    chk("t5_waddr", bus.waddr, 0);
    chk("t5_wdata", bus.wdata, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_ferr", bus.frame_err, 0);
    bus.csb = 1'b1; bus.sck = 1'b0; bus.mosi = 1'b0;
    repeat (4) @(negedge clk);
    rstx = 1'b1;
    repeat (4) @(negedge clk);
    frame_start(8);
    send_byte(8'h00, 8);
    send_byte(8'h5A, 8);
    frame_end(8);
    chk("t5_nwr", wq.size(), 1);
    if (wq.size() == 1) chk("t5_w0", wq[0], 16'h005A);
    chk("t5_nferr", ferr_cnt, 0);
    chk("wen_single_cycle", wen_long, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
